// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared types and encodings for the counter sequence controller.
package cnt_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FIN,
    ST_CLR
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_AUTO    = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DN       = 1'b1;

endpackage

// File: rtl/cnt_seq_rep_cnt.sv
// Period counter: counts completed periods and flags when the next one is the last.
module cnt_seq_rep_cnt #(
  parameter int REPS_W = 4
) (
  input  logic              CLK,
  input  logic              CDN,
  input  logic              clr,
  input  logic              inc,
  input  logic [REPS_W-1:0] reps,
  output logic              last
);

  logic [REPS_W-1:0] count;
  logic [REPS_W-1:0] count_nxt;

  assign count_nxt = count + REPS_W'(1);
  // A zero repeat count means run forever, so it never matches.
  assign last      = (reps != '0) && (count_nxt == reps);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequencer for an external up/down counter chain: load, run, reload, finish, abort-clear.
// Optional build macro CNT_SEQ_CTRL_PINGPONG_EN flips the count direction on every reload.
module cnt_seq_ctrl
  import cnt_seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int REPS_W = 4
) (
  input  logic              CLK,
  input  logic              CDN,
  input  logic              START,
  input  logic              ABORT,
  input  logic              PAUSE,
  input  logic              MODE,
  input  logic              DIR,
  input  logic [WIDTH-1:0]  LDVAL,
  input  logic [REPS_W-1:0] REPS,
  input  logic              TC,
  output logic              CNT_LD,
  output logic              CNT_EN,
  output logic              CNT_DNUP,
  output logic              CNT_CS,
  output logic [WIDTH-1:0]  CNT_D,
  output logic              BUSY,
  output logic              PERIOD,
  output logic              DONE
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sh_ldval;
  logic              sh_dir;
  logic              sh_mode;
  logic [REPS_W-1:0] sh_reps;
  logic              period_q;
  logic              start_take;
  logic              tc_take;
  logic              rep_last;
  logic              finish;
  logic              reload;

  assign start_take = (state_q == ST_IDLE) && START;
  // TC only counts while the counter is actually enabled, and ABORT overrides it.
  assign tc_take    = (state_q == ST_RUN) && !PAUSE && TC && !ABORT;
  assign finish     = (sh_mode == MODE_ONESHOT) || rep_last;
  assign reload     = tc_take && !finish;

  cnt_seq_rep_cnt #(.REPS_W(REPS_W)) u_rep_cnt (
    .CLK  (CLK),
    .CDN  (CDN),
    .clr  (start_take),
    .inc  (tc_take),
    .reps (sh_reps),
    .last (rep_last)
  );

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (tc_take) state_d = finish ? ST_FIN : ST_LOAD;
      ST_FIN:  state_d = ST_IDLE;
      ST_CLR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && ABORT) state_d = ST_CLR;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    BUSY     = (state_q != ST_IDLE);
    CNT_LD   = 1'b0;
    CNT_EN   = 1'b0;
    CNT_DNUP = 1'b0;
    CNT_CS   = 1'b0;
    CNT_D    = '0;
    DONE     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        CNT_LD   = 1'b1;
        CNT_D    = sh_ldval;
        CNT_DNUP = sh_dir;
      end
      ST_RUN: begin
        CNT_EN   = !PAUSE;
        CNT_DNUP = sh_dir;
      end
      ST_FIN:  DONE   = 1'b1;
      ST_CLR:  CNT_CS = 1'b1;
      default: ;
    endcase
  end

  assign PERIOD = period_q;

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      period_q <= 1'b0;
    end else begin
      period_q <= tc_take;
    end
  end

  // Shadow copies keep the sequence immune to input changes after START.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      sh_ldval <= '0;
      sh_dir   <= DIR_UP;
      sh_mode  <= MODE_ONESHOT;
      sh_reps  <= '0;
    end else if (start_take) begin
      sh_ldval <= LDVAL;
      sh_dir   <= DIR;
      sh_mode  <= MODE;
      sh_reps  <= REPS;
    end else if (reload) begin
`ifdef CNT_SEQ_CTRL_PINGPONG_EN
      sh_dir   <= ~sh_dir;
`else
      sh_dir   <= sh_dir;
`endif
    end
  end

endmodule

// File: doc/cnt_seq_ctrl.md
CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: width of the controlled up/down counter chain and of the load value.
REQ-002 Parameter REPS_W, default 4: width of the period-repeat count.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 CDN  in  1  asynchronous, active-low reset.
REQ-005 START  in  1  request a new sequence; honoured only in IDLE.
REQ-006 ABORT  in  1  cancel the sequence in progress.
REQ-007 PAUSE  in  1  hold the count while high.
REQ-008 MODE  in  1  0 = one-shot, 1 = auto-reload.
REQ-009 DIR  in  1  0 = count up, 1 = count down.
REQ-010 LDVAL  in  WIDTH  counter start value.
REQ-011 REPS  in  REPS_W  number of periods in auto-reload; 0 = unlimited.
REQ-012 TC  in  1  terminal carry from the counter chain (CAO of the last stage).
REQ-013 CNT_LD, CNT_EN, CNT_DNUP, CNT_CS  out  1 each  counter load, enable, direction, synchronous clear.
REQ-014 CNT_D  out  WIDTH  counter parallel load data.
REQ-015 BUSY  out  1  high in every state other than IDLE.
REQ-016 PERIOD  out  1  one-cycle pulse per completed period.
REQ-017 DONE  out  1  one-cycle pulse at normal sequence completion.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, RUN, FIN and CLR.
REQ-019 IDLE + START: capture LDVAL, DIR, MODE and REPS into shadow registers, clear the period counter, then go to LOAD.
REQ-020 LOAD: drive CNT_LD=1, CNT_D=shadow LDVAL and CNT_DNUP=shadow DIR for exactly one cycle, then go to RUN.
REQ-021 RUN: CNT_EN = !PAUSE (combinational); CNT_DNUP = shadow DIR.
REQ-022 TC SHALL be sampled only in RUN with CNT_EN=1; at all other times it is ignored.
REQ-023 On a valid TC, PERIOD pulses the next cycle and the period counter increments (modulo 2^REPS_W).
REQ-024 After a valid TC, go to FIN if MODE=0, or if REPS!=0 and the incremented period count equals REPS; otherwise go to LOAD (reload, 1-cycle gap, no count).
REQ-025 FIN: DONE=1 for one cycle with CNT_EN=0, then go to IDLE.
REQ-026 ABORT in any non-IDLE state: go to CLR; CLR drives CNT_CS=1 for one cycle, then goes to IDLE; DONE is not asserted.
REQ-027 ABORT has priority over TC; ABORT and START together in IDLE: START is taken.
REQ-028 START while BUSY SHALL be ignored; the shadow registers SHALL remain unchanged.
REQ-029 Latency: START to first CNT_EN is 2 cycles (IDLE->LOAD->RUN).
REQ-030 CNT_EN, CNT_LD and CNT_CS SHALL be mutually exclusive.

Reset
REQ-031 CDN low, asynchronously: state=IDLE; all outputs 0; shadow registers and period counter 0.
REQ-032 Reset mid-sequence SHALL abandon the sequence with no DONE, PERIOD or CNT_CS pulse.

Configuration
REQ-033 Macro CNT_SEQ_CTRL_PINGPONG_EN defined: in auto-reload, shadow DIR toggles on each reload, so CNT_DNUP alternates per period.
REQ-034 Macro undefined: shadow DIR is fixed for the whole sequence.

Structure
REQ-035 Package cnt_seq_ctrl_pkg SHALL hold the state enum, MODE_ONESHOT=0 / MODE_AUTO=1 and DIR_UP=0 / DIR_DN=1.
REQ-036 The period counter and its compare logic SHALL be the sub-module cnt_seq_rep_cnt.

Verification
REQ-037 WIDTH=2, LDVAL=0, DIR=0, MODE=0, START: CNT_LD at cycle 1, 4 enabled cycles, TC on the 4th, PERIOD then DONE, BUSY low after 7 cycles.
REQ-038 MODE=1, REPS=3, LDVAL=2, DIR=1: exactly 3 PERIOD pulses, 3 CNT_LD pulses, then a single DONE.
REQ-039 PAUSE held 5 cycles mid-RUN: CNT_EN low for those 5 cycles, a TC forced during PAUSE is ignored, completion is delayed by 5 cycles.
REQ-040 ABORT asserted 1 cycle in RUN: next cycle CNT_CS=1, then IDLE, no DONE; START asserted in the same cycle is ignored.
REQ-041 CDN pulsed low in RUN: all outputs 0 immediately; a following START runs normally.
REQ-042 With CNT_SEQ_CTRL_PINGPONG_EN, MODE=1, REPS=2, DIR=0: CNT_DNUP=0 in period 1 and 1 in period 2.
